// File: rtl/trigger_out_events_if.sv
// Event-source bus for trigger_out_events: raw inputs in,
// okTriggerOut pulse vector and debounced buttons out.
interface trigger_out_events_if;
  logic [3:0]  button;
  logic [31:0] count;
  logic [31:0] threshold;
  logic        arm;
  logic [15:0] ep_trigger;
  logic [3:0]  btn_state;

  modport master (
    output button, count, threshold, arm,
    input  ep_trigger, btn_state
  );

  modport slave (
    input  button, count, threshold, arm,
    output ep_trigger, btn_state
  );
endinterface

// File: rtl/trigger_out_events.sv
// Debounced button, counter-watch and heartbeat events turned
// into single-cycle pulses for an okTriggerOut endpoint.
module trigger_out_events #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HB_LOG2         = 24
) (
  input logic                clk1,
  input logic                reset_n,
  trigger_out_events_if.slave bus
);

  localparam logic [15:0] DEB = 16'(DEBOUNCE_CYCLES);

  logic [3:0]         r_sync1;
  logic [3:0]         r_sync2;
  logic [3:0]         r_btn;
  logic [15:0]        r_stab [4];
  logic [31:0]        r_count_q;
  logic               r_q_valid;
  logic [HB_LOG2-1:0] r_hb;
  logic [15:0]        r_ep;

  logic [3:0]  w_btn_nxt;
  logic [3:0]  w_press;
  logic [3:0]  w_rel;
  logic [15:0] w_stab_nxt [4];
  logic        w_cross;
  logic        w_wup;
  logic        w_wdn;
  logic        w_zero;
  logic        w_hb;
  logic [15:0] w_ep;

  // Counter holds the number of consecutive cycles sync has differed
  always_comb begin
    w_btn_nxt = r_btn;
    w_press   = '0;
    w_rel     = '0;
    for (int i = 0; i < 4; i++) begin
      w_stab_nxt[i] = r_stab[i];
      if (r_sync2[i] == r_btn[i]) begin
        w_stab_nxt[i] = '0;
      end else if (r_stab[i] == DEB) begin
        w_stab_nxt[i] = '0;
        w_btn_nxt[i]  = ~r_btn[i];
        w_press[i]    = ~r_btn[i];
        w_rel[i]      = r_btn[i];
      end else begin
        w_stab_nxt[i] = r_stab[i] + 16'd1;
      end
    end
  end

  always_comb begin
    w_cross = bus.arm &&
              (r_count_q < bus.threshold) &&
              (bus.count >= bus.threshold);
    w_wup   = (r_count_q == '1) && (bus.count == '0);
    w_wdn   = (r_count_q == '0) && (bus.count == '1);
    w_zero  = (bus.count == '0) && (r_count_q != '0);
    w_hb    = &r_hb;
    w_ep    = {3'b000, w_hb,
               r_q_valid & w_zero,
               r_q_valid & w_wdn,
               r_q_valid & w_wup,
               r_q_valid & w_cross,
               w_rel, w_press};
  end

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_btn     <= '0;
      for (int i = 0; i < 4; i++) r_stab[i] <= '0;
      r_count_q <= '0;
      r_q_valid <= 1'b0;
      r_hb      <= '0;
      r_ep      <= '0;
    end else begin
      r_sync1   <= ~bus.button;
      r_sync2   <= r_sync1;
      r_btn     <= w_btn_nxt;
      for (int i = 0; i < 4; i++) r_stab[i] <= w_stab_nxt[i];
      r_count_q <= bus.count;
      r_q_valid <= 1'b1;
      r_hb      <= r_hb + 1'b1;
      r_ep      <= w_ep;
    end
  end

  assign bus.ep_trigger = r_ep;
  assign bus.btn_state  = r_btn;

endmodule

// File: tb/tb_trigger_out_events.sv
// Directed bench for trigger_out_events with a pulse scoreboard
// checked every cycle against the DUT outputs.
module tb_trigger_out_events;

  localparam int DEB = 4;
  localparam int HBL = 4;
  localparam int HBP = 1 << HBL;

  typedef struct {
    int         at;
    logic [15:0] pulse;
    logic [3:0]  tog;
  } ev_t;

  logic clk1;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  q[$];
  logic [3:0]  m_btn;
  logic [15:0] exp_ep;

  trigger_out_events_if bus ();

  trigger_out_events #(
    .DEBOUNCE_CYCLES(DEB),
    .HB_LOG2        (HBL)
  ) dut (
    .clk1   (clk1),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  always @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Expected vector: queued pulses due this cycle plus heartbeat
  always @(posedge clk1) begin
    #1;
    exp_ep = '0;
    if (reset_n) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].at == cyc) begin
          exp_ep = exp_ep | q[i].pulse;
          m_btn  = m_btn ^ q[i].tog;
          q.delete(i);
        end
      end
      if (cyc != 0 && (cyc % HBP) == 0) exp_ep[12] = 1'b1;
    end
    checks++;
    assert (bus.ep_trigger === exp_ep) else begin
      errors++;
      $error("FAIL ep_trigger cyc=%0d got %h exp %h",
             cyc, bus.ep_trigger, exp_ep);
    end
    checks++;
    assert (bus.btn_state === m_btn) else begin
      errors++;
      $error("FAIL btn_state cyc=%0d got %b exp %b",
             cyc, bus.btn_state, m_btn);
    end
  end

  task automatic push(input int at, input logic [15:0] p,
                      input logic [3:0] t);
    ev_t e;
    e.at    = at;
    e.pulse = p;
    e.tog   = t;
    q.push_back(e);
  endtask

  task automatic set_count(input logic [31:0] v,
                           input logic [15:0] p);
    @(negedge clk1);
    bus.count = v;
    push(cyc + 1, p, 4'b0000);
  endtask

  task automatic set_btn(input int i, input logic lvl);
    logic [15:0] one;
    logic [3:0]  bit1;
    one  = 16'h0001;
    bit1 = 4'b0001;
    @(negedge clk1);
    bus.button[i] = lvl;
    push(cyc + 3 + DEB,
         lvl ? (one << (4 + i)) : (one << i),
         bit1 << i);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk1);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    m_btn         = '0;
    reset_n       = 1'b0;
    bus.button    = 4'hF;
    bus.count     = 32'hFFFF_FFFF;
    bus.threshold = 32'd100;
    bus.arm       = 1'b1;
    idle(3);
    reset_n = 1'b1;
    idle(3);

    set_count(32'd98,  16'h0000);
    set_count(32'd99,  16'h0000);
    set_count(32'd100, 16'h0100);
    set_count(32'd101, 16'h0000);
    set_count(32'd99,  16'h0000);
    set_count(32'd100, 16'h0100);
    idle(3);

    bus.arm = 1'b0;
    set_count(32'd150, 16'h0000);
    idle(1);
    bus.arm = 1'b1;
    idle(2);
    bus.threshold = 32'd200;
    idle(2);
    bus.threshold = 32'd120;
    idle(2);
    bus.threshold = 32'd100;

    set_count(32'hFFFF_FFFF, 16'h0000);
    set_count(32'h0,         16'h0A00);
    bus.arm = 1'b0;
    set_count(32'hFFFF_FFFF, 16'h0400);
    set_count(32'd5,         16'h0000);
    set_count(32'h0,         16'h0800);
    idle(3);

    set_btn(2, 1'b0);
    idle(12);
    set_btn(2, 1'b1);
    idle(12);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk1);
      bus.button[0] = i[0];
      idle(2);
    end
    set_btn(0, 1'b0);
    idle(12);

    @(negedge clk1);
    bus.button[0] = 1'b1;
    idle(3);
    set_count(32'hFFFF_FFFF, 16'h0400);
    @(posedge clk1);
    #2;
    reset_n = 1'b0;
    q.delete();
    m_btn = '0;
    #1;
    checks++;
    assert (bus.ep_trigger === 16'h0000) else begin
      errors++;
      $error("FAIL rst_ep got %h exp 0000", bus.ep_trigger);
    end
    checks++;
    assert (bus.btn_state === 4'b0000) else begin
      errors++;
      $error("FAIL rst_btn got %b exp 0000", bus.btn_state);
    end
    idle(4);
    reset_n = 1'b1;
    idle(40);

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain got %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
